// File: rtl/seq_detector_param.sv
// seq_detector_param: serial bit-pattern detector with a runtime-loadable LEN-bit pattern.
// It supports overlapping and non-overlapping detection, a Mealy (combinational) or Moore
// (registered) match pulse, an input-enable qualifier and a saturating match counter.
//
// Ports:
//   i_clk        clock; all state updates on the rising edge
//   i_rst        synchronous active-low reset
//   i_en         accept i_din on this edge
//   i_din        serial data bit
//   i_load       capture i_pat_in and clear the detection history (has priority over i_en)
//   i_pat_in     new pattern; the MSB is the first bit expected on i_din
//   i_ovl        1 = overlapping detection, 0 = non-overlapping detection
//   o_dout       match pulse
//   o_match_cnt  saturating count of matches
//   o_cnt_sat    high while o_match_cnt is all ones
//   o_fill       number of valid history bits, 0..LEN-1
module seq_detector_param #(
  parameter int unsigned    LEN      = 3,
  parameter logic [LEN-1:0] PAT_INIT = 3'b101,
  parameter bit             MEALY    = 1'b1,
  parameter int unsigned    CNT_W    = 8,
  localparam int unsigned   FW       = $clog2(LEN)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_din,
  input  logic             i_load,
  input  logic [LEN-1:0]   i_pat_in,
  input  logic             i_ovl,
  output logic             o_dout,
  output logic [CNT_W-1:0] o_match_cnt,
  output logic             o_cnt_sat,
  output logic [FW-1:0]    o_fill
);

  localparam logic [FW-1:0] FillFull = FW'(LEN - 1);

  logic [LEN-1:0]   r_pat, w_pat_nxt;
  logic [LEN-2:0]   r_hist, w_hist_nxt;
  logic [FW-1:0]    r_fill, w_fill_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [LEN-1:0]   w_cand;
  logic             w_hit;
  logic             w_cnt_sat;

  assign w_cand    = {r_hist, i_din};
  assign w_cnt_sat = &r_cnt;
  // Gating by i_rst keeps the Mealy pulse low while reset is asserted.
  assign w_hit = i_rst & i_en & ~i_load & (r_fill == FillFull) & (w_cand == r_pat);

  // State register; r_fill doubles as the detector FSM state (0 = idle, LEN-1 = primed).
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_pat  <= PAT_INIT;
      r_hist <= '0;
      r_fill <= '0;
      r_cnt  <= '0;
    end else begin
      r_pat  <= w_pat_nxt;
      r_hist <= w_hist_nxt;
      r_fill <= w_fill_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_pat_nxt  = r_pat;
    w_hist_nxt = r_hist;
    w_fill_nxt = r_fill;
    w_cnt_nxt  = r_cnt;
    if (i_load) begin
      w_pat_nxt  = i_pat_in;
      w_hist_nxt = '0;
      w_fill_nxt = '0;
    end else if (i_en) begin
      w_hist_nxt = w_cand[LEN-2:0];
      if (w_hit) begin
        // Overlap reuses the history; non-overlap demands LEN fresh bits.
        w_fill_nxt = i_ovl ? FillFull : '0;
        if (!w_cnt_sat) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end else if (r_fill != FillFull) begin
        w_fill_nxt = r_fill + 1'b1;
      end
    end
  end

  if (MEALY) begin : g_mealy
    assign o_dout = w_hit;
  end else begin : g_moore
    logic r_dout_q;
    always_ff @(posedge i_clk) begin
      if (!i_rst) begin
        r_dout_q <= 1'b0;
      end else begin
        r_dout_q <= w_hit;
      end
    end
    assign o_dout = r_dout_q;
  end

  assign o_match_cnt = r_cnt;
  assign o_cnt_sat   = w_cnt_sat;
  assign o_fill      = r_fill;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed bench for seq_detector_param. Four instances share one
// stimulus bus: A (LEN=3, Mealy), M (LEN=3, Moore), C (LEN=4, Mealy), S (LEN=3, CNT_W=2).
// Inputs change on the falling edge; outputs are sampled 1 time unit later, so Mealy dout
// reflects the bit being presented and counters/fill reflect the state before its edge.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst, en, din, load, ovl;
  logic [3:0] pat_in;

  always #5 clk = ~clk;

  logic       a_dout, m_dout, c_dout, s_dout;
  logic [7:0] a_cnt, m_cnt, c_cnt;
  logic [1:0] s_cnt;
  logic       a_sat, m_sat, c_sat, s_sat;
  logic [1:0] a_fill, m_fill, c_fill, s_fill;

  seq_detector_param #(.LEN(3), .PAT_INIT(3'b101), .MEALY(1'b1), .CNT_W(8)) u_a (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_din(din), .i_load(load), .i_pat_in(pat_in[2:0]),
    .i_ovl(ovl), .o_dout(a_dout), .o_match_cnt(a_cnt), .o_cnt_sat(a_sat), .o_fill(a_fill)
  );
  seq_detector_param #(.LEN(3), .PAT_INIT(3'b101), .MEALY(1'b0), .CNT_W(8)) u_m (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_din(din), .i_load(load), .i_pat_in(pat_in[2:0]),
    .i_ovl(ovl), .o_dout(m_dout), .o_match_cnt(m_cnt), .o_cnt_sat(m_sat), .o_fill(m_fill)
  );
  seq_detector_param #(.LEN(4), .PAT_INIT(4'b0000), .MEALY(1'b1), .CNT_W(8)) u_c (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_din(din), .i_load(load), .i_pat_in(pat_in),
    .i_ovl(ovl), .o_dout(c_dout), .o_match_cnt(c_cnt), .o_cnt_sat(c_sat), .o_fill(c_fill)
  );
  seq_detector_param #(.LEN(3), .PAT_INIT(3'b101), .MEALY(1'b1), .CNT_W(2)) u_s (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_din(din), .i_load(load), .i_pat_in(pat_in[2:0]),
    .i_ovl(ovl), .o_dout(s_dout), .o_match_cnt(s_cnt), .o_cnt_sat(s_sat), .o_fill(s_fill)
  );

  typedef struct {
    string      tag;
    int         sel;   // 0=A 1=M 2=C 3=S
    logic       dout;
    logic       sat;
    logic [7:0] cnt;
    logic [1:0] fill;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus on the falling edge.
  task automatic step(input logic r, input logic e, input logic d, input logic l,
                      input logic [3:0] p);
    @(negedge clk);
    rst = r; en = e; din = d; load = l; pat_in = p;
  endtask

  task automatic push(input string tag, input int sel, input logic d, input logic s,
                      input int c, input int f);
    exp_t x;
    x.tag = tag; x.sel = sel; x.dout = d; x.sat = s; x.cnt = 8'(c); x.fill = 2'(f);
    sb.push_back(x);
  endtask

  // Pop every pending expectation and compare it against the selected instance.
  task automatic drain();
    exp_t x;
    logic       od, os;
    logic [7:0] oc;
    logic [1:0] of;
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      case (x.sel)
        0:       begin od = a_dout; os = a_sat; oc = a_cnt;        of = a_fill; end
        1:       begin od = m_dout; os = m_sat; oc = m_cnt;        of = m_fill; end
        2:       begin od = c_dout; os = c_sat; oc = c_cnt;        of = c_fill; end
        default: begin od = s_dout; os = s_sat; oc = {6'd0, s_cnt}; of = s_fill; end
      endcase
      chk({x.tag, ".dout"}, 32'(od), 32'(x.dout));
      chk({x.tag, ".sat"},  32'(os), 32'(x.sat));
      chk({x.tag, ".cnt"},  32'(oc), 32'(x.cnt));
      chk({x.tag, ".fill"}, 32'(of), 32'(x.fill));
    end
  endtask

  // Data step on one instance: drive bit d with en=1, then check expectations.
  task automatic bit_in(input string tag, input int sel, input logic d, input logic ed,
                        input logic es, input int ec, input int ef);
    step(1'b1, 1'b1, d, 1'b0, 4'b0000);
    push(tag, sel, ed, es, ec, ef);
    drain();
  endtask

  task automatic idle(input string tag, input int sel, input logic ed, input logic es,
                      input int ec, input int ef);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
    push(tag, sel, ed, es, ec, ef);
    drain();
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; din = 1'b0; load = 1'b0; ovl = 1'b1; pat_in = 4'b0000;

    // Reset state; Mealy output held low while rst=0 even with en=1, din=1.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
    push("rst_a", 0, 1'b0, 1'b0, 0, 0);
    push("rst_m", 1, 1'b0, 1'b0, 0, 0);
    push("rst_c", 2, 1'b0, 1'b0, 0, 0);
    push("rst_s", 3, 1'b0, 1'b0, 0, 0);
    drain();

    // 1: overlapping, 1010101 -> hits on bits 3, 5, 7.
    ovl = 1'b1;
    do_reset();
    bit_in("t1b1", 0, 1'b1, 1'b0, 1'b0, 0, 0);
    bit_in("t1b2", 0, 1'b0, 1'b0, 1'b0, 0, 1);
    bit_in("t1b3", 0, 1'b1, 1'b1, 1'b0, 0, 2);
    bit_in("t1b4", 0, 1'b0, 1'b0, 1'b0, 1, 2);
    bit_in("t1b5", 0, 1'b1, 1'b1, 1'b0, 1, 2);
    bit_in("t1b6", 0, 1'b0, 1'b0, 1'b0, 2, 2);
    bit_in("t1b7", 0, 1'b1, 1'b1, 1'b0, 2, 2);
    idle("t1end", 0, 1'b0, 1'b0, 3, 2);

    // 2: non-overlapping -> hits on bits 3 and 7, fill back to 0 after bit 3.
    ovl = 1'b0;
    do_reset();
    bit_in("t2b1", 0, 1'b1, 1'b0, 1'b0, 0, 0);
    bit_in("t2b2", 0, 1'b0, 1'b0, 1'b0, 0, 1);
    bit_in("t2b3", 0, 1'b1, 1'b1, 1'b0, 0, 2);
    bit_in("t2b4", 0, 1'b0, 1'b0, 1'b0, 1, 0);
    bit_in("t2b5", 0, 1'b1, 1'b0, 1'b0, 1, 1);
    bit_in("t2b6", 0, 1'b0, 1'b0, 1'b0, 1, 2);
    bit_in("t2b7", 0, 1'b1, 1'b1, 1'b0, 1, 2);
    idle("t2end", 0, 1'b0, 1'b0, 2, 0);

    // 3: Moore pulses one cycle after the Mealy instance on the same stream.
    ovl = 1'b1;
    do_reset();
    bit_in("t3b1", 1, 1'b1, 1'b0, 1'b0, 0, 0);
    bit_in("t3b2", 1, 1'b0, 1'b0, 1'b0, 0, 1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
    push("t3b3m", 1, 1'b0, 1'b0, 0, 2);
    push("t3b3a", 0, 1'b1, 1'b0, 0, 2);
    drain();
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
    push("t3p1m", 1, 1'b1, 1'b0, 1, 2);
    push("t3p1a", 0, 1'b0, 1'b0, 1, 2);
    drain();
    idle("t3p2m", 1, 1'b0, 1'b0, 1, 2);

    // 4: LEN=4, load 1101, stream 11 <stall x5> 01101.
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b1101);
    push("t4ld", 2, 1'b0, 1'b0, 0, 0);
    drain();
    bit_in("t4b1", 2, 1'b1, 1'b0, 1'b0, 0, 0);
    bit_in("t4b2", 2, 1'b1, 1'b0, 1'b0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      idle($sformatf("t4st%0d", i), 2, 1'b0, 1'b0, 0, 2);
    end
    bit_in("t4b3", 2, 1'b0, 1'b0, 1'b0, 0, 2);
    bit_in("t4b4", 2, 1'b1, 1'b1, 1'b0, 0, 3);
    bit_in("t4b5", 2, 1'b1, 1'b0, 1'b0, 1, 3);
    bit_in("t4b6", 2, 1'b0, 1'b0, 1'b0, 1, 3);
    bit_in("t4b7", 2, 1'b1, 1'b1, 1'b0, 1, 3);
    idle("t4end", 2, 1'b0, 1'b0, 2, 3);

    // 5: 2-bit counter saturates at 3 on the third match and holds on the fourth.
    do_reset();
    bit_in("t5b1", 3, 1'b1, 1'b0, 1'b0, 0, 0);
    bit_in("t5b2", 3, 1'b0, 1'b0, 1'b0, 0, 1);
    bit_in("t5b3", 3, 1'b1, 1'b1, 1'b0, 0, 2);
    bit_in("t5b4", 3, 1'b0, 1'b0, 1'b0, 1, 2);
    bit_in("t5b5", 3, 1'b1, 1'b1, 1'b0, 1, 2);
    bit_in("t5b6", 3, 1'b0, 1'b0, 1'b0, 2, 2);
    bit_in("t5b7", 3, 1'b1, 1'b1, 1'b0, 2, 2);
    bit_in("t5b8", 3, 1'b0, 1'b0, 1'b1, 3, 2);
    bit_in("t5b9", 3, 1'b1, 1'b1, 1'b1, 3, 2);
    idle("t5end", 3, 1'b0, 1'b1, 3, 2);

    // 6a: reset mid-stream discards history; next 1 is not a hit, fill=1 afterwards.
    do_reset();
    bit_in("t6b1", 0, 1'b1, 1'b0, 1'b0, 0, 0);
    bit_in("t6b2", 0, 1'b0, 1'b0, 1'b0, 0, 1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
    push("t6rst", 0, 1'b0, 1'b0, 0, 2);
    drain();
    bit_in("t6b3", 0, 1'b1, 1'b0, 1'b0, 0, 0);
    idle("t6f1", 0, 1'b0, 1'b0, 0, 1);

    // 6b: load on a would-be completing bit suppresses the hit and installs 110.
    bit_in("t6b4", 0, 1'b0, 1'b0, 1'b0, 0, 1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110);
    push("t6ld", 0, 1'b0, 1'b0, 0, 2);
    drain();
    idle("t6ld1", 0, 1'b0, 1'b0, 0, 0);
    bit_in("t6c1", 0, 1'b1, 1'b0, 1'b0, 0, 0);
    bit_in("t6c2", 0, 1'b1, 1'b0, 1'b0, 0, 1);
    bit_in("t6c3", 0, 1'b0, 1'b1, 1'b0, 0, 2);
    idle("t6end", 0, 1'b0, 1'b0, 1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector, generalising the fixed 3-bit "101" Mealy detector to a runtime-loadable pattern of LEN bits. It supports overlapping and non-overlapping detection, a Mealy or Moore output style, an input-enable qualifier and a saturating match counter. It sits on a serial data path and flags every completed occurrence of the programmed pattern.

## Interface
Parameters:
- LEN, 3: pattern length in bits; legal range 2..16.
- PAT_INIT, 3'b101: pattern loaded at reset, LEN bits wide.
- MEALY, 1: 1 selects a combinational Mealy output; 0 selects a registered Moore output.
- CNT_W, 8: width of the match counter.

Ports (all synchronous to clk):
- clk, in, 1: sole clock; everything updates on the rising edge.
- rst, in, 1: synchronous, active-low reset. It is sampled on the rising clk edge.
- en, in, 1: din is accepted on any edge where en=1.
- din, in, 1: serial data bit.
- load, in, 1: on the edge, captures pat_in into the pattern register and clears the detection history.
- pat_in, in, LEN: new pattern. The MSB is the first bit expected on din.
- ovl, in, 1: 1 selects overlapping detection; 0 selects non-overlapping detection. It is sampled every cycle.
- dout, out, 1: match pulse.
- match_cnt, out, CNT_W: number of matches, saturating.
- cnt_sat, out, 1: high while match_cnt is all ones.
- fill, out, $clog2(LEN): number of valid history bits, 0..LEN-1.

## Operation
Registers:
- pat: LEN bits.
- hist: the last LEN-1 accepted bits; hist[0] is the newest.
- fill
- match_cnt
- dout_q: used in Moore mode only.

Match condition:
- cand = {hist[LEN-2:0], din}.
- hit = en & (fill == LEN-1) & (cand == pat) & ~load.

Accept cycle (en=1, load=0):
- hist shifts left, with din entering at bit 0.
- If there is no hit: fill <= min(fill+1, LEN-1).
- If there is a hit and ovl=1: fill stays at LEN-1, so history bits are reused.
- If there is a hit and ovl=0: fill <= 0, so the next match needs LEN fresh bits.
- On a hit, match_cnt increments unless it is all ones, in which case it holds.

Stall cycle (en=0, load=0):
- All registers hold.
- hit is 0.

Load cycle (load=1):
- pat <= pat_in.
- fill <= 0 and hist <= 0.
- dout_q <= 0.
- din is ignored and match_cnt holds.
- load has priority over en.

Output:
- When MEALY=1: dout = hit, combinational from din, en and the registers.
- When MEALY=0: dout = dout_q, where dout_q <= hit.

Other rules:
- cnt_sat = &match_cnt.
- match_cnt clears only on reset.
- The fill counter acts as the FSM state. For LEN=3 its states are 0 (idle), 1 and 2 (primed). The transitions are as listed above.

## Timing
Reset values (rst=0 at an edge):
- pat = PAT_INIT.
- hist = 0.
- fill = 0.
- match_cnt = 0, cnt_sat = 0.
- dout_q = 0.

Reset behaviour:
- In Mealy mode, dout is forced to 0 whenever rst=0, because hit is gated by rst.
- Reset mid-stream discards partial history; the first match after reset needs LEN new bits.

Latency:
- Mealy: dout rises in the same cycle as the final pattern bit on din.
- Moore: dout rises one cycle later.
- match_cnt updates on the edge that completes the match.

Boundary conditions:
- A match cannot occur until LEN bits have been accepted since reset or load.
- Changing ovl mid-stream takes effect on the next hit decision.
- A load in the same cycle as a would-be hit suppresses the hit and leaves the count unchanged.
- With en=0 on the final bit, no match occurs until that bit is presented with en=1.

## Test plan
1. LEN=3, PAT_INIT=101, MEALY=1, ovl=1. Stream 1,0,1,0,1,0,1 with en=1 → dout=1 on bits 3, 5 and 7, same cycle; match_cnt=3.
2. Same stream with ovl=0 → dout=1 on bits 3 and 7 only; match_cnt=2; fill returns to 0 after bit 3.
3. MEALY=0, ovl=1, stream 1,0,1 → dout=0 during bit 3 and dout=1 for one cycle after it; a Mealy instance on the same stimulus pulses one cycle earlier.
4. LEN=4 with a load of pat_in=1101, then 1,1,0,1,1,0,1 → hits on bits 4 and 7 with ovl=1; toggling en low between bits 2 and 3 for 5 cycles changes nothing except delaying the hits.
5. CNT_W=2, ovl=1, stream 1,0,1,0,1,0,1,0,1 (4 matches) → match_cnt goes 1, 2, 3, 3; cnt_sat rises on the third match.
6. Assert rst=0 after input 1,0, then release and send 1 → no hit, fill=1. Also drive load=1 coincident with a completing bit → dout=0, match_cnt unchanged, fill=0, pat updated.
